// File: rtl/decoder_onehot_seq.sv
// Purpose : registered one-hot line sequencer (load / step with wrap / hold / clear)
//           with a combinational output-enable mask.
// Latency : state, idx, active, wrap, err update one clk after mode/sel are sampled.
//           out follows en combinationally.
// Backpressure : none. A new mode is accepted every cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (restarts at line RESET_IDX)
//   mode    00 hold, 01 load, 10 step, 11 clear
//   sel     binary line number used by load
//   en      output enable; masks out only, never touches state
//   out     one-hot lines = state & {NUM_OUT{en}}
//   idx     registered binary index of the set line (0 when none)
//   active  registered OR of state
//   wrap    one-cycle pulse when a step goes from line NUM_OUT-1 to line 0
//   err     one-cycle pulse when a load asks for a line >= NUM_OUT
module decoder_onehot_seq #(
    parameter int SEL_W     = 3,
    parameter int NUM_OUT   = 8,
    parameter int RESET_IDX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [NUM_OUT-1:0] out,
    output logic [SEL_W-1:0]   idx,
    output logic               active,
    output logic               wrap,
    output logic               err
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    localparam logic [NUM_OUT-1:0] LINE0     = {{(NUM_OUT-1){1'b0}}, 1'b1};
    localparam logic [NUM_OUT-1:0] RST_STATE = LINE0 << RESET_IDX;
    localparam logic [SEL_W-1:0]   RST_IDX   = SEL_W'(RESET_IDX);
    // One extra bit so NUM_OUT == 2**SEL_W is representable in the compare.
    localparam logic [SEL_W:0]     NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

    logic [NUM_OUT-1:0] state_q, state_nxt;
    logic [SEL_W-1:0]   idx_q, idx_nxt;
    logic               active_q, active_nxt;
    logic               wrap_q, wrap_nxt;
    logic               err_q, err_nxt;
    logic               sel_ok;

    assign sel_ok = ({1'b0, sel} < NUM_OUT_W);

    always_comb begin
        state_nxt  = state_q;
        idx_nxt    = idx_q;
        active_nxt = active_q;
        wrap_nxt   = 1'b0;
        err_nxt    = 1'b0;
        case (mode)
            MODE_HOLD: begin
            end
            MODE_LOAD: begin
                if (sel_ok) begin
                    state_nxt  = LINE0 << sel;
                    idx_nxt    = sel;
                    active_nxt = 1'b1;
                end else begin
                    err_nxt    = 1'b1;
                end
            end
            MODE_STEP: begin
                if (state_q == '0) begin
                    // Restart after clear: no wrap, since no line was left.
                    state_nxt  = LINE0;
                    idx_nxt    = '0;
                    active_nxt = 1'b1;
                end else if (state_q[NUM_OUT-1]) begin
                    state_nxt  = LINE0;
                    idx_nxt    = '0;
                    wrap_nxt   = 1'b1;
                end else begin
                    state_nxt  = state_q << 1;
                    idx_nxt    = idx_q + SEL_W'(1);
                end
            end
            MODE_CLEAR: begin
                state_nxt  = '0;
                idx_nxt    = '0;
                active_nxt = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_STATE;
            idx_q    <= RST_IDX;
            active_q <= 1'b1;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            idx_q    <= idx_nxt;
            active_q <= active_nxt;
            wrap_q   <= wrap_nxt;
            err_q    <= err_nxt;
        end
    end

    assign out    = state_q & {NUM_OUT{en}};
    assign idx    = idx_q;
    assign active = active_q;
    assign wrap   = wrap_q;
    assign err    = err_q;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Bench for decoder_onehot_seq: three instances sharing stimulus
// (A: 8 lines reset 0, B: 6 lines reset 0, C: 8 lines reset 2).
// Each instance is tracked by a line-number reference model.
module tb_decoder_onehot_seq;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       en;

    logic [7:0] out_a, out_c;
    logic [5:0] out_b;
    logic [2:0] idx_a, idx_b, idx_c;
    logic       act_a, act_b, act_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       err_a, err_b, err_c;

    decoder_onehot_seq #(.SEL_W(3), .NUM_OUT(8), .RESET_IDX(0)) u_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .en(en),
        .out(out_a), .idx(idx_a), .active(act_a), .wrap(wrap_a), .err(err_a));
    decoder_onehot_seq #(.SEL_W(3), .NUM_OUT(6), .RESET_IDX(0)) u_b (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .en(en),
        .out(out_b), .idx(idx_b), .active(act_b), .wrap(wrap_b), .err(err_b));
    decoder_onehot_seq #(.SEL_W(3), .NUM_OUT(8), .RESET_IDX(2)) u_c (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .en(en),
        .out(out_c), .idx(idx_c), .active(act_c), .wrap(wrap_c), .err(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: current line number per instance, -1 when cleared.
    int cur [3];
    bit mwrap [3];
    bit merr [3];

    function automatic int nout(input int i);
        return (i == 1) ? 6 : 8;
    endfunction

    function automatic int ridx(input int i);
        return (i == 2) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            cur[i] = ridx(i);
            mwrap[i] = 0;
            merr[i] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] m, input logic [2:0] s);
        for (int i = 0; i < 3; i++) begin
            mwrap[i] = 0;
            merr[i] = 0;
            case (m)
                2'd1: if (int'(s) < nout(i)) cur[i] = int'(s); else merr[i] = 1;
                2'd2: begin
                    if (cur[i] < 0) cur[i] = 0;
                    else if (cur[i] == nout(i) - 1) begin cur[i] = 0; mwrap[i] = 1; end
                    else cur[i] = cur[i] + 1;
                end
                2'd3: cur[i] = -1;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] o [3];
        logic [2:0] ix [3];
        logic a [3], w [3], e [3];
        int exp_out;
        o[0] = out_a; o[1] = {2'b00, out_b}; o[2] = out_c;
        ix[0] = idx_a; ix[1] = idx_b; ix[2] = idx_c;
        a[0] = act_a; a[1] = act_b; a[2] = act_c;
        w[0] = wrap_a; w[1] = wrap_b; w[2] = wrap_c;
        e[0] = err_a; e[1] = err_b; e[2] = err_c;
        for (int i = 0; i < 3; i++) begin
            exp_out = (cur[i] >= 0 && en) ? (1 << cur[i]) : 0;
            chk($sformatf("model_out[%0d]", i), int'(o[i]), exp_out);
            chk($sformatf("model_idx[%0d]", i), int'(ix[i]), (cur[i] >= 0) ? cur[i] : 0);
            chk($sformatf("model_active[%0d]", i), int'(a[i]), (cur[i] >= 0) ? 1 : 0);
            chk($sformatf("model_wrap[%0d]", i), int'(w[i]), int'(mwrap[i]));
            chk($sformatf("model_err[%0d]", i), int'(e[i]), int'(merr[i]));
        end
    endtask

    // Drive one cycle's inputs (away from the edge), clock it, check #1 later.
    task automatic cyc(input logic [1:0] m, input logic [2:0] s, input logic e);
        mode = m;
        sel  = s;
        en   = e;
        @(posedge clk);
        if (rst_n) model_step(m, s);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse between clock edges, released on a falling edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_out_a_now", int'(out_a), en ? 32'h01 : 0);
        chk("arst_out_c_now", int'(out_c), en ? 32'h04 : 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [2:0] sel;
        logic       en;
        logic [7:0] out;
        logic [2:0] idx;
        logic       act;
        logic       wrap;
        logic       err;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // Expected values are for instance A (8 lines, reset at line 0).
        tbl[0]  = '{2'd2, 3'd0, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{2'd2, 3'd0, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2'd2, 3'd0, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{2'd2, 3'd0, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{2'd2, 3'd0, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{2'd2, 3'd0, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{2'd2, 3'd0, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{2'd2, 3'd0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{2'd0, 3'd0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{2'd1, 3'd3, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{2'd3, 3'd0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{2'd0, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{2'd2, 3'd0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{2'd1, 3'd5, 1'b0, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{2'd0, 3'd0, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{2'd1, 3'd5, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        mode  = 2'd0;
        sel   = 3'd0;
        en    = 1'b1;
        #7;
        model_reset();
        check_all();
        chk("rst_out_a", int'(out_a), 32'h01);
        chk("rst_out_c", int'(out_c), 32'h04);
        chk("rst_idx_c", int'(idx_c), 2);
        chk("rst_act_c", int'(act_c), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table against instance A.
        for (int k = 0; k < 16; k++) begin
            cyc(tbl[k].mode, tbl[k].sel, tbl[k].en);
            chk($sformatf("tbl%0d_out", k),  int'(out_a),  int'(tbl[k].out));
            chk($sformatf("tbl%0d_idx", k),  int'(idx_a),  int'(tbl[k].idx));
            chk($sformatf("tbl%0d_act", k),  int'(act_a),  int'(tbl[k].act));
            chk($sformatf("tbl%0d_wrap", k), int'(wrap_a), int'(tbl[k].wrap));
            chk($sformatf("tbl%0d_err", k),  int'(err_a),  int'(tbl[k].err));
        end

        // Six-line instance: top line, out-of-range load, wrap on step.
        cyc(2'd1, 3'd5, 1'b1);
        chk("n6_load5_out", int'(out_b), 32'h20);
        cyc(2'd1, 3'd6, 1'b1);
        chk("n6_load6_out", int'(out_b), 32'h20);
        chk("n6_load6_err", int'(err_b), 1);
        cyc(2'd1, 3'd7, 1'b1);
        chk("n6_load7_err", int'(err_b), 1);
        cyc(2'd0, 3'd0, 1'b1);
        chk("n6_hold_err", int'(err_b), 0);
        cyc(2'd2, 3'd0, 1'b1);
        chk("n6_step_out", int'(out_b), 32'h01);
        chk("n6_step_wrap", int'(wrap_b), 1);
        cyc(2'd0, 3'd0, 1'b1);
        chk("n6_hold_wrap", int'(wrap_b), 0);

        // Load, step twice, asynchronous reset mid-cycle, then hold.
        cyc(2'd1, 3'd4, 1'b1);
        cyc(2'd2, 3'd0, 1'b1);
        cyc(2'd2, 3'd0, 1'b1);
        chk("pre_rst_out_a", int'(out_a), 32'h40);
        async_reset();
        cyc(2'd0, 3'd0, 1'b1);
        chk("post_rst_hold_a", int'(out_a), 32'h01);
        chk("post_rst_hold_c", int'(out_c), 32'h04);
        cyc(2'd1, 3'd2, 1'b1);
        chk("r2_load2_out", int'(out_c), 32'h04);
        chk("r2_load2_err", int'(err_c), 0);

        // Randomized stimulus against the reference model.
        for (int k = 0; k < 2000; k++) begin
            cyc(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 7) != 0));
            if (k % 400 == 200) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_onehot_seq.md
Name: decoder_onehot_seq

Overview:
- Registered, parametrised successor to the combinational 3-to-8 decoder.
- Holds a one-hot selection register of NUM_OUT lines.
- The register can be loaded from a binary select, stepped (rotated) with wrap-around, held or cleared.
- Serves as the processor's control-step / register-select sequencer; the output enable masks all lines as the old decoder's en did.

Parameters:
- SEL_W, 3, width of binary select and of the index output.
- NUM_OUT, 8, number of one-hot lines; legal range 2..2**SEL_W.
- RESET_IDX, 0, line asserted after reset; must be < NUM_OUT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  operation: 00 hold, 01 load, 10 step, 11 clear.
- sel  input  SEL_W  binary line number used by load.
- en  input  1  output enable, combinational mask on out.
- out  output  NUM_OUT  one-hot lines, equal to state & {NUM_OUT{en}}.
- idx  output  SEL_W  registered binary index of the asserted line; 0 when no line is asserted.
- active  output  1  registered; 1 when any state bit is set.
- wrap  output  1  registered one-cycle pulse on step from line NUM_OUT-1 to line 0.
- err  output  1  registered one-cycle pulse on load with sel >= NUM_OUT.

Behaviour:
- Internal state register: NUM_OUT bits, always one-hot or all-zero, never more than one bit set.
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state = 1<<RESET_IDX, idx = RESET_IDX, active = 1, wrap = 0, err = 0.
  - Reset deasserted mid-sequence restarts at RESET_IDX; no in-flight operation is remembered.
- All updates occur on the rising clk edge.
- wrap and err default to 0 every cycle unless set by the rules below; they never stay high two cycles without a repeated trigger.
- mode 00 hold: state and idx unchanged.
- mode 01 load:
  - If sel < NUM_OUT: state = 1<<sel, idx = sel, active = 1.
  - If sel >= NUM_OUT: state and idx unchanged, err = 1 for one cycle.
  - Loading the currently selected line is legal and produces no pulse.
- mode 10 step:
  - If state has bit k set with k < NUM_OUT-1: state = 1<<(k+1), idx = k+1.
  - If k = NUM_OUT-1: state = 1, idx = 0, wrap = 1 for one cycle.
  - If state is all-zero (after clear): state = 1, idx = 0, active = 1, no wrap pulse.
- mode 11 clear: state = 0, idx = 0, active = 0.
- Latency: state, idx, active, wrap and err are updated one clock after mode/sel is sampled.
- en is combinational only: it never alters state, so out returns to the held line when en is re-asserted.
- Inputs carry no handshake; a new mode is accepted every cycle, so back-to-back steps advance one line per cycle.
- With NUM_OUT < 2**SEL_W, unused line indices are never reached by step or load.
- Invariants a bench must check every cycle:
  - out is zero or a power of two.
  - idx equals the position of the set state bit.
  - active equals OR of state.

Test Plan:
- Reset, then 7 consecutive steps (defaults, en=1) -> out 0x01,0x02,…,0x80 on successive cycles; idx 0..7; wrap=0 throughout.
- From out=0x80, one step -> out=0x01, idx=0, wrap=1 for exactly one cycle, then wrap=0 under hold.
- NUM_OUT=6, SEL_W=3: load sel=5 -> out=0x20; load sel=6 -> out stays 0x20, err=1 for one cycle; step -> out=0x01, wrap=1.
- Load sel=3, then clear -> out=0, active=0, idx=0; step -> out=0x01, active=1, wrap=0; en=0 at any point -> out=0 while idx unchanged.
- Load sel=4, step twice, assert rst_n=0 asynchronously between clock edges -> out=0x01 (RESET_IDX=0) immediately; after release, hold keeps 0x01.
- RESET_IDX=2: reset -> out=0x04, idx=2, active=1; load sel=2 -> no change, err=0.
